// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for a single-port synchronous RAM.
// Address path is combinational from the owner; read data returns one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wrEn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_wrEn,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              wrEn,
  output logic [ADDR_W-1:0] addr_toRAM,
  output logic [DATA_W-1:0] data_toRAM,
  input  logic [DATA_W-1:0] data_fromRAM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       r_rv0;
  logic       r_rv1;

  logic       w_beat0;
  logic       w_beat1;
  logic       w_end0;
  logic       w_end1;
  logic [3:0] w_cnt_nxt;

  assign m0_gnt    = (r_state == OWN0);
  assign m1_gnt    = (r_state == OWN1);
  assign w_beat0   = m0_gnt & m0_req;
  assign w_beat1   = m1_gnt & m1_req;
  assign w_cnt_nxt = r_cnt + 4'd1;
  // Ownership ends on a dropped request or on the last allowed beat.
  assign w_end0    = !m0_req || (w_cnt_nxt == LP_MAX);
  assign w_end1    = !m1_req || (w_cnt_nxt == LP_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 1'b1;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      r_rv0 <= w_beat0 & ~m0_wrEn;
      r_rv1 <= w_beat1 & ~m1_wrEn;
      unique case (r_state)
        IDLE: begin
          r_cnt <= 4'd0;
          if (m0_req && (!m1_req || r_last)) begin
            r_state <= OWN0;
            r_last  <= 1'b0;
          end else if (m1_req) begin
            r_state <= OWN1;
            r_last  <= 1'b1;
          end
        end
        OWN0: begin
          if (w_end0) begin
            r_cnt <= 4'd0;
            if (m1_req) begin
              r_state <= OWN1;
              r_last  <= 1'b1;
            end else if (!m0_req) begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        OWN1: begin
          if (w_end1) begin
            r_cnt <= 4'd0;
            if (m0_req) begin
              r_state <= OWN0;
              r_last  <= 1'b0;
            end else if (!m1_req) begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    wrEn       = 1'b0;
    addr_toRAM = '0;
    data_toRAM = '0;
    if (w_beat0) begin
      wrEn       = m0_wrEn;
      addr_toRAM = m0_addr;
      data_toRAM = m0_wdata;
    end else if (w_beat1) begin
      wrEn       = m1_wrEn;
      addr_toRAM = m1_addr;
      data_toRAM = m1_wdata;
    end
  end

  assign m0_rvalid = r_rv0;
  assign m1_rvalid = r_rv1;
  assign m0_rdata  = r_rv0 ? data_fromRAM : '0;
  assign m1_rdata  = r_rv1 ? data_fromRAM : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle RAM.
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wrEn;
  logic [12:0] m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [15:0] m0_rdata;
  logic        m1_req, m1_wrEn;
  logic [12:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [15:0] m1_rdata;
  logic        wrEn;
  logic [12:0] addr_toRAM;
  logic [15:0] data_toRAM;
  logic [15:0] data_fromRAM = '0;

  logic [15:0] mem [0:8191];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(16), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wrEn(m0_wrEn), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wrEn(m1_wrEn), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid),
    .wrEn(wrEn), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
    .data_fromRAM(data_fromRAM)
  );

  always @(posedge clk) begin
    if (wrEn) mem[addr_toRAM] <= data_toRAM;
    data_fromRAM <= mem[addr_toRAM];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    m0_req = 0; m0_wrEn = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wrEn = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, m0_gnt, m1_gnt}, 32'd0);
    chk({tag, "_rv"}, {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk({tag, "_rd"}, {m0_rdata, m1_rdata}, 32'd0);
    chk({tag, "_ram"}, {2'd0, wrEn, addr_toRAM, data_toRAM}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h0004] = 16'h1234;
    mem[13'h0010] = 16'h0ABC;

    do_reset();
    settle();
    chk_all_zero("reset");

    // single read by m0
    m0_req = 1; m0_addr = 13'h0004;
    settle();
    chk("rd_c0_gnt", {31'd0, m0_gnt}, 32'd0);
    step(); settle();
    chk("rd_c1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    chk("rd_c1_addr", {19'd0, addr_toRAM}, 32'h0004);
    chk("rd_c1_rv", {31'd0, m0_rvalid}, 32'd0);
    step();
    m0_req = 0;
    settle();
    chk("rd_c2_rv", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("rd_c2_data", {16'd0, m0_rdata}, 32'h1234);
    chk("rd_c2_ram0", {2'd0, wrEn, addr_toRAM, data_toRAM}, 32'd0);
    step(); settle();
    chk("rd_c3_idle", {29'd0, m0_gnt, m1_gnt, m0_rvalid}, 32'd0);

    // tie after reset, held: m0 x8, m1 x8, m0
    do_reset();
    m0_req = 1; m0_addr = 13'h0010;
    m1_req = 1; m1_addr = 13'h0004;
    for (int c = 1; c <= 17; c++) begin
      logic [1:0] exp_g;
      step(); settle();
      exp_g = (c <= 8 || c == 17) ? 2'b10 : 2'b01;
      chk($sformatf("tie_c%0d_gnt", c), {30'd0, m0_gnt, m1_gnt},
          {30'd0, exp_g});
      if (c == 9) begin
        chk("hand_rv", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
        chk("hand_data", {16'd0, m0_rdata}, 32'h0ABC);
        chk("hand_addr", {19'd0, addr_toRAM}, 32'h0004);
      end
      if (c == 10) begin
        chk("m1_rv", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
        chk("m1_data", {16'd0, m1_rdata}, 32'h1234);
      end
    end
    idle_in();
    step(); step(); settle();
    chk("tie_end_idle", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    // lone m1 over the burst limit
    m1_req = 1; m1_addr = 13'h0004;
    for (int c = 1; c <= 20; c++) begin
      step(); settle();
      chk($sformatf("lone_c%0d_gnt", c), {30'd0, m0_gnt, m1_gnt}, 32'd1);
    end
    idle_in();
    step(); step(); settle();
    chk("lone_end", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    // write passthrough then readback
    m1_req = 1; m1_wrEn = 1; m1_addr = 13'h1FFF; m1_wdata = 16'hBEEF;
    step(); settle();
    chk("wr_ram", {2'd0, wrEn, addr_toRAM, data_toRAM},
        {2'd0, 1'b1, 13'h1FFF, 16'hBEEF});
    step();
    m1_wrEn = 0; m1_wdata = 16'h0000;
    settle();
    chk("wr_no_rv", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("rb_addr", {19'd0, addr_toRAM}, 32'h1FFF);
    step();
    m1_req = 0;
    settle();
    chk("rb_rv", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
    chk("rb_data", {16'd0, m1_rdata}, 32'hBEEF);
    chk("nobeat_ram", {2'd0, wrEn, addr_toRAM, data_toRAM}, 32'd0);
    idle_in();
    step(); step();

    // reset in the middle of an m0 read burst
    m0_req = 1; m0_addr = 13'h0004;
    step(); step(); step();
    rst = 1'b1;
    settle();
    chk("mid_pre_gnt", {31'd0, m0_gnt}, 32'd1);
    step();
    rst = 1'b0;
    m1_req = 1;
    settle();
    chk_all_zero("mid_rst");
    step(); settle();
    chk("post_tie", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    idle_in();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
